// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back retire queue.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_REG_AW = 5;
  localparam int WB_DATA_W = 32;

  localparam logic [WB_REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [WB_REG_AW-1:0] a3;
    logic [WB_DATA_W-1:0] wd;
    logic [WB_DATA_W-1:0] pc;
    logic [WB_DATA_W-1:0] instr;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Combinational youngest-match search over the queue entries starting at the read pointer.
module wb_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic [REG_AW-1:0]        chk_a_i,
  input  logic [REG_AW-1:0]        a3_i [DEPTH],
  input  logic [DATA_W-1:0]        wd_i [DEPTH],
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx_s;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx_s  = '0;
    if (chk_a_i != REG_ZERO) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx_s = rd_ptr_i + PW'(k);
        if (valid_i[idx_s] && (a3_i[idx_s] == chk_a_i)) begin
          hit_o  = 1'b1;
          data_o = wd_i[idx_s];
        end else begin
          hit_o  = hit_o;
        end
      end
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/w_wb_queue.sv
// Write-back retire queue driving the single register-file write port; MDU results take priority.
// Define WB_TRACE_EN to print a trace line for each non-$0 register-file write.
module w_wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_AW-1:0]          in_a3,
  input  logic [DATA_W-1:0]          in_wd,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic                       mdu_we,
  input  logic [REG_AW-1:0]          mdu_a3,
  input  logic [DATA_W-1:0]          mdu_wd,
  input  logic [DATA_W-1:0]          mdu_pc,
  input  logic [DATA_W-1:0]          mdu_instr,
  output logic                       grf_we,
  output logic [REG_AW-1:0]          grf_a3,
  output logic [DATA_W-1:0]          grf_wd,
  output logic [DATA_W-1:0]          grf_pc,
  output logic [DATA_W-1:0]          grf_instr,
  input  logic [REG_AW-1:0]          chk_a1,
  input  logic [REG_AW-1:0]          chk_a2,
  output logic                       chk_hit1,
  output logic                       chk_hit2,
  output logic [DATA_W-1:0]          chk_data1,
  output logic [DATA_W-1:0]          chk_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_s, pop_s;
  wb_entry_t        head_s;
  logic [REG_AW-1:0] a3_s [DEPTH];
  logic [DATA_W-1:0] wd_s [DEPTH];

  // Handshake, port arbitration and next-state pointers/occupancy.
  always_comb begin
    in_ready  = !reset && (count_q != CW'(DEPTH));
    push_s    = in_valid && in_ready && (in_a3 != REG_ZERO);
    pop_s     = !reset && !mdu_we && (count_q != '0);
    head_s    = mem_q[rd_ptr_q];
    grf_we    = 1'b0;
    grf_a3    = '0;
    grf_wd    = '0;
    grf_pc    = '0;
    grf_instr = '0;
    if (reset) begin
      grf_we = 1'b0;
    end else if (mdu_we) begin
      grf_we    = 1'b1;
      grf_a3    = mdu_a3;
      grf_wd    = mdu_wd;
      grf_pc    = mdu_pc;
      grf_instr = mdu_instr;
    end else if (count_q != '0) begin
      grf_we    = 1'b1;
      grf_a3    = head_s.a3;
      grf_wd    = head_s.wd;
      grf_pc    = head_s.pc;
      grf_instr = head_s.instr;
    end else begin
      grf_we = 1'b0;
    end

    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    wr_ptr_d = wr_ptr_q + PW'(push_s);
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (push_s) begin
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry storage; only written on an accepted non-$0 push, never during reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= '{a3: in_a3, wd: in_wd, pc: in_pc, instr: in_instr};
    end
  end

  // Unpack entry fields for the lookup units.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      a3_s[i] = mem_q[i].a3;
      wd_s[i] = mem_q[i].wd;
    end
  end

  assign count = count_q;

  wb_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_lookup1 (
    .chk_a_i (chk_a1),
    .a3_i    (a3_s),
    .wd_i    (wd_s),
    .valid_i (valid_q),
    .rd_ptr_i(rd_ptr_q),
    .hit_o   (chk_hit1),
    .data_o  (chk_data1)
  );

  wb_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_lookup2 (
    .chk_a_i (chk_a2),
    .a3_i    (a3_s),
    .wd_i    (wd_s),
    .valid_i (valid_q),
    .rd_ptr_i(rd_ptr_q),
    .hit_o   (chk_hit2),
    .data_o  (chk_data2)
  );

`ifdef WB_TRACE_EN
  // Register-file write trace.
  always_ff @(posedge clk) begin
    if (grf_we && (grf_a3 != REG_ZERO) && !reset) begin
      $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_w_wb_queue.sv
// Self-checking bench for w_wb_queue: directed scenarios plus random traffic against a queue model.
module tb_w_wb_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_a3;
  logic [31:0] in_wd, in_pc, in_instr;
  logic        mdu_we;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd, mdu_pc, mdu_instr;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc, grf_instr;
  logic [4:0]  chk_a1, chk_a2;
  logic        chk_hit1, chk_hit2;
  logic [31:0] chk_data1, chk_data2;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dut_q_writes = 0;

  always #5 clk = ~clk;

  w_wb_queue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a3(in_a3), .in_wd(in_wd),
    .in_pc(in_pc), .in_instr(in_instr),
    .mdu_we(mdu_we), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc), .mdu_instr(mdu_instr),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc), .grf_instr(grf_instr),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .chk_data1(chk_data1), .chk_data2(chk_data2), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest queued write to register a (none for $0).
  task automatic look(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a3 == a) begin
          h = 1'b1;
          d = q[i].wd;
          break;
        end
      end
    end
  endtask

  // Check every output against the model, clock once, then advance the model.
  task automatic step();
    logic        rdy, h;
    logic [31:0] d;
    ent_t        e;
    #2;
    rdy = !reset && (q.size() != D);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("count", 32'(count), 32'(q.size()));
    e = '{a3: 5'd0, wd: 32'd0, pc: 32'd0, instr: 32'd0};
    if (!reset && mdu_we) e = '{a3: mdu_a3, wd: mdu_wd, pc: mdu_pc, instr: mdu_instr};
    else if (!reset && q.size() > 0) e = q[0];
    chk("grf_we", 32'(grf_we), 32'(!reset && (mdu_we || q.size() > 0)));
    chk("grf_a3", 32'(grf_a3), 32'(e.a3));
    chk("grf_wd", grf_wd, e.wd);
    chk("grf_pc", grf_pc, e.pc);
    chk("grf_instr", grf_instr, e.instr);
    look(chk_a1, h, d);
    chk("chk_hit1", 32'(chk_hit1), 32'(h));
    chk("chk_data1", chk_data1, d);
    look(chk_a2, h, d);
    chk("chk_hit2", 32'(chk_hit2), 32'(h));
    chk("chk_data2", chk_data2, d);
    if (grf_we && !mdu_we) dut_q_writes++;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (!mdu_we && q.size() > 0) void'(q.pop_front());
      if (in_valid && rdy && in_a3 != 5'd0)
        q.push_back('{a3: in_a3, wd: in_wd, pc: in_pc, instr: in_instr});
    end
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    mdu_we   = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    chk("drained_count", 32'(count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a3 = 5'd0; in_wd = 32'd0; in_pc = 32'd0; in_instr = 32'd0;
    mdu_we = 1'b0; mdu_a3 = 5'd0; mdu_wd = 32'd0; mdu_pc = 32'd0; mdu_instr = 32'd0;
    chk_a1 = 5'd0; chk_a2 = 5'd0;
    @(posedge clk); #1;
    step();
    reset = 1'b0;
    step();

    // 1: single push retires one cycle later
    in_valid = 1'b1; in_a3 = 5'd5; in_wd = 32'h1234; in_pc = 32'h3000; in_instr = $urandom;
    step();
    in_valid = 1'b0;
    chk("t1_we", 32'(grf_we), 32'd1);
    chk("t1_a3", 32'(grf_a3), 32'd5);
    chk("t1_wd", grf_wd, 32'h1234);
    chk("t1_pc", grf_pc, 32'h3000);
    step();
    chk("t1_we_after", 32'(grf_we), 32'd0);
    chk("t1_count_after", 32'(count), 32'd0);

    // 2: push to $0 is discarded
    in_valid = 1'b1; in_a3 = 5'd0; in_wd = 32'hFFFF; chk_a1 = 5'd0;
    step();
    in_valid = 1'b0;
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_we", 32'(grf_we), 32'd0);
    chk("t2_hit1", 32'(chk_hit1), 32'd0);

    // 3: MDU holds the port while the queue fills
    mdu_we = 1'b1; mdu_a3 = 5'd9; mdu_wd = $urandom; mdu_pc = $urandom; mdu_instr = $urandom;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_a3 = 5'(i); in_wd = $urandom; in_pc = $urandom; in_instr = $urandom;
      step();
      chk("t3_mdu_a3", 32'(grf_a3), 32'd9);
    end
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; mdu_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t3_order", 32'(grf_a3), 32'(i));
      step();
    end

    // 4: youngest duplicate wins the lookup
    mdu_we = 1'b1;
    in_valid = 1'b1; in_a3 = 5'd7; in_wd = 32'h1; step();
    in_wd = 32'h2; step();
    in_valid = 1'b0; chk_a1 = 5'd7; chk_a2 = 5'd8;
    #1;
    chk("t4_hit1", 32'(chk_hit1), 32'd1);
    chk("t4_data1", chk_data1, 32'h2);
    chk("t4_hit2", 32'(chk_hit2), 32'd0);
    chk("t4_data2", chk_data2, 32'd0);
    step();
    drain();

    // 5: reset flushes queued entries
    mdu_we = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      in_valid = 1'b1; in_a3 = 5'(i); in_wd = $urandom; step();
    end
    in_valid = 1'b0; mdu_we = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_we", 32'(grf_we), 32'd0);
    step();

    // 6: continuous pushes with periodic MDU stalls, pointers wrap
    dut_q_writes = 0;
    for (int n = 0, cyc = 0; n < 12 && cyc < 60; cyc++) begin
      in_valid = 1'b1; in_a3 = 5'(n + 1); in_wd = $urandom; in_pc = $urandom; in_instr = $urandom;
      mdu_we = (cyc % 3 == 2);
      mdu_a3 = 5'd20;
      if (q.size() != D) n++;
      step();
    end
    drain();
    chk("t6_written", 32'(dut_q_writes), 32'd12);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a3 = 5'($urandom_range(0, 7)); in_wd = $urandom; in_pc = $urandom; in_instr = $urandom;
      mdu_we = ($urandom_range(0, 3) == 0);
      mdu_a3 = 5'($urandom_range(0, 31)); mdu_wd = $urandom; mdu_pc = $urandom; mdu_instr = $urandom;
      chk_a1 = 5'($urandom_range(0, 7)); chk_a2 = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
